// File: rtl/alsu_cmd_driver.sv
// alsu_cmd_driver: initiator-side sequencer for the ALSU.
// Accepts one packed command at a time, applies it to the ALSU ports for
// LATENCY+hold+1 cycles, then returns the sampled ALSU result with a
// sequence tag over a valid/ready response channel.
module alsu_cmd_driver #(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 8,
    parameter int LED_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    // command channel
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [20:0]      cmd_data,
    // response channel
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [5:0]       rsp_out,
    output logic             rsp_invalid,
    output logic [TAG_W-1:0] rsp_tag,
    // ALSU stimulus
    output logic             alsu_rst,
    output logic [2:0]       alsu_opcode,
    output logic [2:0]       alsu_A,
    output logic [2:0]       alsu_B,
    output logic             alsu_cin,
    output logic             alsu_serial_in,
    output logic             alsu_direction,
    output logic             alsu_red_op_A,
    output logic             alsu_red_op_B,
    output logic             alsu_bypass_A,
    output logic             alsu_bypass_B,
    // ALSU result
    input  logic [5:0]       alsu_out,
    input  logic [LED_W-1:0] alsu_leds
);

    // Wide enough for the largest wait load, LATENCY + 15.
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] hold;
        logic       clr;
        logic [2:0] opcode;
        logic [2:0] a;
        logic [2:0] b;
        logic       cin;
        logic       serial_in;
        logic       direction;
        logic       red_op_a;
        logic       red_op_b;
        logic       bypass_a;
        logic       bypass_b;
    } cmd_t;

    state_t           state;
    cmd_t             cmd;
    logic [CNT_W-1:0] wait_cnt;
    logic [TAG_W-1:0] tag_cnt;

    assign cmd = cmd_t'(cmd_data);

    // Sequencer: accept a command, hold it on the ALSU, capture and return the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            tag_cnt        <= '0;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_out        <= '0;
            rsp_invalid    <= 1'b0;
            rsp_tag        <= '0;
            alsu_rst       <= 1'b1;
            alsu_opcode    <= '0;
            alsu_A         <= '0;
            alsu_B         <= '0;
            alsu_cin       <= 1'b0;
            alsu_serial_in <= 1'b0;
            alsu_direction <= 1'b0;
            alsu_red_op_A  <= 1'b0;
            alsu_red_op_B  <= 1'b0;
            alsu_bypass_A  <= 1'b0;
            alsu_bypass_B  <= 1'b0;
        end else begin
            // NOTE: default non-blocking assignment first, overridden later in the
            // same block; the last assignment wins, so alsu_rst is a one-cycle pulse
            // whenever only the accept branch raises it.
            alsu_rst <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        alsu_rst       <= cmd.clr;
                        alsu_opcode    <= cmd.opcode;
                        alsu_A         <= cmd.a;
                        alsu_B         <= cmd.b;
                        alsu_cin       <= cmd.cin;
                        alsu_serial_in <= cmd.serial_in;
                        alsu_direction <= cmd.direction;
                        alsu_red_op_A  <= cmd.red_op_a;
                        alsu_red_op_B  <= cmd.red_op_b;
                        alsu_bypass_A  <= cmd.bypass_a;
                        alsu_bypass_B  <= cmd.bypass_b;
                        rsp_tag        <= tag_cnt;
                        tag_cnt        <= tag_cnt + TAG_W'(1);
                        wait_cnt       <= CNT_W'(LATENCY) + CNT_W'(cmd.hold);
                        cmd_ready      <= 1'b0;
                        state          <= WAIT;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        rsp_out     <= alsu_out;
                        rsp_invalid <= |alsu_leds;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    cmd_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alsu_cmd_driver.sv
// Self-checking bench for alsu_cmd_driver. A small behavioural ALSU
// (input register + output register, FULL_ADDER on) sits on the alsu_*
// ports; expected responses are predicted per command from the ALSU rules.
module tb_alsu_cmd_driver;

    localparam int LATENCY = 2;
    localparam int TAG_W   = 8;
    localparam int LED_W   = 16;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [20:0]      cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [5:0]       rsp_out;
    logic             rsp_invalid;
    logic [TAG_W-1:0] rsp_tag;
    logic             alsu_rst;
    logic [2:0]       alsu_opcode, alsu_A, alsu_B;
    logic             alsu_cin, alsu_serial_in, alsu_direction;
    logic             alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
    logic [5:0]       alsu_out;
    logic [LED_W-1:0] alsu_leds;

    int n_checks = 0;
    int n_errors = 0;
    logic [TAG_W-1:0] tag_exp = '0;

    alsu_cmd_driver #(.LATENCY(LATENCY), .TAG_W(TAG_W), .LED_W(LED_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
        .rsp_invalid(rsp_invalid), .rsp_tag(rsp_tag),
        .alsu_rst(alsu_rst), .alsu_opcode(alsu_opcode), .alsu_A(alsu_A), .alsu_B(alsu_B),
        .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in), .alsu_direction(alsu_direction),
        .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
        .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
        .alsu_out(alsu_out), .alsu_leds(alsu_leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural ALSU ----------------
    // f layout: [15:13] opcode [12:10] A [9:7] B [6] cin [5] serial_in
    //           [4] direction [3] red_op_A [2] red_op_B [1] bypass_A [0] bypass_B
    function automatic logic [6:0] alsu_step(input logic [15:0] f, input logic [5:0] prev);
        logic [2:0] op, a, b;
        logic       inv;
        logic [5:0] r;
        op  = f[15:13];
        a   = f[12:10];
        b   = f[9:7];
        inv = (op[2:1] == 2'b11) || ((f[3] | f[2]) && (op[2:1] != 2'b00));
        r   = '0;
        if (inv)       r = '0;
        else if (f[1]) r = {3'b0, a};
        else if (f[0]) r = {3'b0, b};
        else begin
            case (op)
                3'b000:  r = f[3] ? {5'b0, &a} : (f[2] ? {5'b0, &b} : {3'b0, a & b});
                3'b001:  r = f[3] ? {5'b0, ^a} : (f[2] ? {5'b0, ^b} : {3'b0, a ^ b});
                3'b010:  r = 6'(a) + 6'(b) + 6'(f[6]);
                3'b011:  r = 6'(a) * 6'(b);
                3'b100:  r = f[4] ? {prev[4:0], f[5]} : {f[5], prev[5:1]};
                default: r = f[4] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
            endcase
        end
        return {inv, r};
    endfunction

    logic [15:0] alsu_vec;
    logic [15:0] alsu_in_q;
    logic [6:0]  alsu_next;
    assign alsu_vec  = {alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in, alsu_direction,
                        alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B};
    assign alsu_next = alsu_step(alsu_in_q, alsu_out);

    always @(posedge clk or posedge alsu_rst) begin
        if (alsu_rst) begin
            alsu_in_q <= '0;
            alsu_out  <= '0;
            alsu_leds <= '0;
        end else begin
            alsu_in_q <= alsu_vec;
            alsu_out  <= alsu_next[5:0];
            alsu_leds <= alsu_next[6] ? '1 : '0;
        end
    end

    // ---------------- reference model ----------------
    // Returns {known, invalid, out} for one command. With clr the ALSU starts
    // from zero and the command takes effect 'hold' times; without clr only
    // results that do not depend on the previous out are predictable.
    function automatic logic [7:0] predict(input logic [20:0] c);
        logic [6:0] st, st_hi;
        logic [5:0] s;
        logic       inv;
        s   = '0;
        inv = 1'b0;
        if (c[16]) begin
            for (int i = 0; i < int'(c[20:17]); i++) begin
                st  = alsu_step(c[15:0], s);
                s   = st[5:0];
                inv = st[6];
            end
            return {1'b1, inv, s};
        end
        st    = alsu_step(c[15:0], 6'h00);
        st_hi = alsu_step(c[15:0], 6'h3f);
        return {st == st_hi, st[6], st[5:0]};
    endfunction

    function automatic logic [20:0] mk(input logic [3:0] hold, input logic clr, input logic [2:0] op,
                                       input logic [2:0] a, input logic [2:0] b, input logic [6:0] ctl);
        return {hold, clr, op, a, b, ctl};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Issue one command and follow it through to the response handshake.
    task automatic run_cmd(input logic [20:0] c, input int rdy_delay, input bit noisy);
        logic [7:0]       pr;
        logic [TAG_W-1:0] my_tag;
        int               target;
        int               k;
        bit               seen;
        pr     = predict(c);
        target = LATENCY + 1 + int'(c[20:17]);
        k = 0;
        while (cmd_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (cmd_ready !== 1'b1) begin
            check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_data  = c;
        my_tag    = tag_exp;
        tag_exp   = tag_exp + TAG_W'(1);
        @(negedge clk);
        if (noisy) cmd_data = 21'($urandom);
        else       cmd_valid = 1'b0;
        check("alsu_fields_apply", 32'(alsu_vec), 32'(c[15:0]));
        check("alsu_rst_pulse", 32'(alsu_rst), 32'(c[16]));
        check("cmd_ready_wait", 32'(cmd_ready), 32'd0);
        check("rsp_valid_wait", 32'(rsp_valid), 32'd0);
        for (int e = 1; e < target; e++) begin
            @(negedge clk);
            if (noisy) cmd_data = 21'($urandom);
            check("alsu_fields_stable", 32'(alsu_vec), 32'(c[15:0]));
            check("alsu_rst_low", 32'(alsu_rst), 32'd0);
            check("cmd_ready_wait", 32'(cmd_ready), 32'd0);
            check("rsp_valid_early", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        check("rsp_valid_latency", 32'(rsp_valid), 32'd1);
        seen = (rsp_valid === 1'b1);
        k = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            seen = (rsp_valid === 1'b1);
            k++;
        end
        if (!seen) begin
            cmd_valid = 1'b0;
            return;
        end
        for (int d = 0; d <= rdy_delay; d++) begin
            if (pr[7]) check("rsp_out", 32'(rsp_out), 32'(pr[5:0]));
            check("rsp_invalid", 32'(rsp_invalid), 32'(pr[6]));
            check("rsp_tag", 32'(rsp_tag), 32'(my_tag));
            check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
            check("cmd_ready_resp", 32'(cmd_ready), 32'd0);
            if (d < rdy_delay) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("cmd_ready_back", 32'(cmd_ready), 32'd1);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [20:0] c;
        logic [7:0]  pr;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        rsp_ready = 1'b0;

        // 1. reset then add
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_alsu_rst", 32'(alsu_rst), 32'd1);
        check("rst_alsu_fields", 32'(alsu_vec), 32'd0);
        check("rst_rsp_out", 32'(rsp_out), 32'd0);
        check("rst_rsp_invalid", 32'(rsp_invalid), 32'd0);
        check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        rst = 1'b1;
        #1;
        check("alsu_rst_after_release", 32'(alsu_rst), 32'd1);
        @(negedge clk);
        check("alsu_rst_first_edge", 32'(alsu_rst), 32'd0);
        check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
        run_cmd(mk(4'd0, 1'b0, 3'b010, 3'd5, 3'd1, 7'b1000000), 0, 1'b0);

        // 2. AND back-to-back, tag 1
        run_cmd(mk(4'd0, 1'b0, 3'b000, 3'd5, 3'd3, 7'b0000000), 1, 1'b0);

        // 5. clear after a nonzero result
        run_cmd(mk(4'd1, 1'b1, 3'b010, 3'd5, 3'd1, 7'b1000000), 0, 1'b0);

        // 3. hold/latency with shift (clr so the start value is known)
        run_cmd(mk(4'd3, 1'b1, 3'b100, 3'd2, 3'd6, 7'b0110000), 0, 1'b1);

        // 4. invalid opcode with 5 cycles of backpressure
        run_cmd(mk(4'd0, 1'b0, 3'b110, 3'd1, 3'd2, 7'b0000000), 5, 1'b0);

        // randomized commands (enough to wrap the tag counter)
        for (int i = 0; i < 260; i++) begin
            c  = 21'($urandom);
            pr = predict(c);
            if (!pr[7]) c[16] = 1'b1;
            run_cmd(c, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // 6. reset during WAIT
        c = mk(4'd4, 1'b0, 3'b010, 3'd3, 3'd4, 7'b0000000);
        while (cmd_ready !== 1'b1) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = c;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midwait_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midwait_cmd_ready", 32'(cmd_ready), 32'd0);
        check("midwait_alsu_rst", 32'(alsu_rst), 32'd1);
        check("midwait_alsu_fields", 32'(alsu_vec), 32'd0);
        check("midwait_rsp_tag", 32'(rsp_tag), 32'd0);
        @(negedge clk);
        rst     = 1'b1;
        tag_exp = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("midwait_no_rsp", 32'(rsp_valid), 32'd0);
        end
        run_cmd(mk(4'd0, 1'b0, 3'b011, 3'd7, 3'd6, 7'b0000000), 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alsu_cmd_driver.md
Name: alsu_cmd_driver

Overview:
Initiator-side sequencer that drives the ALSU's input ports from a packed command stream and returns the ALSU's registered result. Each command carries a tag and a hold count. The ALSU in the datapath sits directly on this block's alsu_* ports. Commands arrive over a valid/ready handshake. Responses (out, invalid flag, tag) leave over a second valid/ready handshake. This lets upstream control logic, or a bench, run the ALSU without cycle-accurate knowledge of its pipeline.

Parameters:
LATENCY, 2, ALSU clock edges from input change to registered out (input register plus output register).
TAG_W, 8, width of the response sequence tag.
LED_W, 16, width of the ALSU leds bus.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  driver can accept a command.
cmd_data  in  21  packed command, fields as follows:
- [20:17] hold
- [16] clr
- [15:13] opcode
- [12:10] A
- [9:7] B
- [6] cin
- [5] serial_in
- [4] direction
- [3] red_op_A
- [2] red_op_B
- [1] bypass_A
- [0] bypass_B
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response.
rsp_out  out  6  sampled ALSU out.
rsp_invalid  out  1  OR-reduction of sampled alsu_leds.
rsp_tag  out  TAG_W  sequence number of the originating command.
alsu_rst  out  1  active-high reset to the ALSU.
alsu_opcode, alsu_A, alsu_B  out  3 each  ALSU operands and opcode.
alsu_cin, alsu_serial_in, alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B  out  1 each  ALSU controls.
alsu_out  in  6  ALSU result.
alsu_leds  in  LED_W  ALSU invalid indicator.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; tag counter 0; all alsu_* data/control outputs 0.
  - alsu_rst=1; it deasserts on the first rising clk edge after rst releases.
  - rsp_valid=0, rsp_out=0, rsp_invalid=0, rsp_tag=0, cmd_ready=0 during reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at edge E0: all alsu_* fields are registered from cmd_data at E0.
  - If clr=1, alsu_rst=1 for exactly one cycle (E0 to E1). The other fields are still applied.
  - rsp_tag latches the tag counter; the counter increments (wraps at 2^TAG_W).
  - Wait counter loads LATENCY+hold; go to WAIT.
- WAIT:
  - cmd_ready=0; alsu_* held stable (except alsu_rst clearing).
  - Counter decrements each edge. At edge E0+LATENCY+1+hold, capture alsu_out into rsp_out and |alsu_leds into rsp_invalid, then go to RESP.
  - hold=N keeps the command applied N extra cycles, so shift/rotate ops iterate N+1 times.
- RESP:
  - rsp_valid=1; rsp_out/rsp_invalid/rsp_tag stable until rsp_valid&rsp_ready.
  - On the handshake edge, go to IDLE; rsp_valid=0 the next cycle.
- No command overlap: cmd_ready is 1 only in IDLE, and the earliest next acceptance is the edge after the response handshake.
- alsu_* ports keep the last command's values while idle; they are never returned to 0 between commands.
- clr with hold>0: alsu_rst still lasts one cycle only; the remaining hold cycles run normally.
- rst asserted in WAIT or RESP: immediate return to the reset values above; the pending response is lost; tag counter returns to 0.
- rsp_ready held high in RESP: the response completes in one cycle.
- cmd_valid held high in WAIT or RESP: ignored (cmd_ready=0). cmd_data need not be stable.
- Counter width: 5 bits, enough for max LATENCY+hold = 2+15.

Test Plan:
1. Reset then add: rst low 2 cycles then high; command opcode=010, A=5, B=1, cin=1, hold=0 (ALSU built with FULL_ADDER="ON") -> rsp_valid rises exactly 3 edges after acceptance; rsp_out=7, rsp_invalid=0, rsp_tag=0; alsu_rst=1 until the first edge after release.
2. AND then tag increment: opcode=000, A=5, B=3, issued back-to-back after a zero-delay rsp_ready -> rsp_out=1, rsp_tag=1; the next cmd_ready=1 falls one cycle after the response handshake.
3. Hold/latency: opcode=100, hold=3 -> alsu_* stable for 6 cycles; rsp_valid exactly 6 edges after acceptance; cmd_ready=0 throughout.
4. Invalid plus backpressure: opcode=110, red_op_A=0, rsp_ready low 5 cycles -> rsp_invalid=1; rsp_out/rsp_tag unchanged for all 5 cycles; cmd_ready=0 until rsp_ready=1.
5. Clear: clr=1, opcode=010, A=5, B=1 after a nonzero result -> alsu_rst high exactly 1 cycle; rsp_out matches the ALSU result of that command after clearing; tag increments.
6. Reset mid-WAIT: assert rst 1 cycle after acceptance with hold=4 -> rsp_valid never asserts; alsu_* return to 0; alsu_rst=1; the next command returns rsp_tag=0.
